// File: rtl/lcd_sequencer_pkg.sv
// lcd_pkg: shared FSM states, power-on init table and HD44780 command codes.
// Contents: state_t enum, init_step_t record, INIT_SEQ table, CMD_* constants.
package lcd_pkg;
  typedef enum logic [2:0] {POWER, INIT, IDLE, SETUP, EN_HI, EN_LO, WAIT} state_t;
  localparam logic [7:0] CMD_FUNCSET = 8'h28;
  localparam logic [7:0] CMD_DISPON  = 8'h0C;
  localparam logic [7:0] CMD_CLEAR   = 8'h01;
  localparam logic [7:0] CMD_ENTRY   = 8'h06;
  typedef struct packed {
    logic       is_byte;
    logic [7:0] val;
    logic       long_wait;
  } init_step_t;
  localparam int INIT_LEN = 8;
  // Single-nibble steps keep their nibble in val[7:4] so they go out as the high nibble.
  localparam init_step_t INIT_SEQ [INIT_LEN] = '{
    '{1'b0, 8'h30, 1'b1},
    '{1'b0, 8'h30, 1'b0},
    '{1'b0, 8'h30, 1'b0},
    '{1'b0, 8'h20, 1'b0},
    '{1'b1, CMD_FUNCSET, 1'b0},
    '{1'b1, CMD_DISPON, 1'b0},
    '{1'b1, CMD_CLEAR, 1'b1},
    '{1'b1, CMD_ENTRY, 1'b0}
  };
endpackage

// File: rtl/lcd_sequencer_if.sv
// lcd_sequencer_if: requester handshake plus HD44780 pin bundle.
// master = requester (drives in_valid/in_data/in_rs); slave = sequencer (drives the rest).
interface lcd_sequencer_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_rs;
  logic       in_ready;
  logic       init_done;
  logic       busy;
  logic [3:0] lcd_data;
  logic       lcd_en;
  logic       lcd_rs;
  modport master (output in_valid, in_data, in_rs,
                  input in_ready, init_done, busy, lcd_data, lcd_en, lcd_rs);
  modport slave (input in_valid, in_data, in_rs,
                 output in_ready, init_done, busy, lcd_data, lcd_en, lcd_rs);
endinterface

// File: rtl/lcd_sequencer_prescaler.sv
// lcd_prescaler: divides CLK into a one-cycle tick every DIVIDER cycles.
// Ports: CLK, RST (async, high), clr_i (sync restart of the count), tick_o.
module lcd_prescaler #(
  parameter int DIVIDER = 12
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr_i,
  output logic tick_o
);
  localparam int CW = DIVIDER > 1 ? $clog2(DIVIDER) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
  assign tick_o = cnt_q == CW'(DIVIDER - 1);
  always_comb cnt_d = (clr_i || tick_o) ? '0 : cnt_q + 1'b1;
  always_ff @(posedge CLK or posedge RST)
    if (RST) cnt_q <= '0;
    else     cnt_q <= cnt_d;
endmodule

// File: rtl/lcd_sequencer.sv
// lcd_sequencer: HD44780 4-bit write sequencer with power-on init.
// Ports: CLK, RST (async, high), bus (lcd_sequencer_if.slave: byte handshake in, LCD pins out).
module lcd_sequencer
  import lcd_pkg::*;
#(
  parameter int DIVIDER   = 12,
  parameter int DELAY_BIT = 6
) (
  input logic            CLK,
  input logic            RST,
  lcd_sequencer_if.slave bus
);
  localparam int DW = DELAY_BIT + 9;
  localparam logic [DW-1:0] SHORT_LAST = DW'((1 << DELAY_BIT) - 1);
  localparam logic [DW-1:0] LONG_LAST  = DW'((1 << (DELAY_BIT + 6)) - 1);
  localparam logic [DW-1:0] PWR_LAST   = DW'((1 << (DELAY_BIT + 8)) - 1);
  state_t        state_q, state_d;
  logic [7:0]    data_q, data_d;
  logic          rs_q, rs_d, lo_q, lo_d, single_q, single_d, long_q, long_d, done_q, done_d;
  logic [3:0]    idx_q, idx_d;
  logic [DW-1:0] dly_q, dly_d;
  logic          tick, clr, dly_end, accept;
  init_step_t    step;
  lcd_prescaler #(.DIVIDER(DIVIDER)) u_pre (.CLK, .RST, .clr_i(clr), .tick_o(tick));
  assign step    = INIT_SEQ[idx_q[2:0]];
  assign accept  = bus.in_valid && bus.in_ready;
  assign dly_end = tick && dly_q == (state_q == POWER ? PWR_LAST : long_q ? LONG_LAST : SHORT_LAST);
  assign clr     = state_d != state_q || lo_d != lo_q;
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    rs_d     = rs_q;
    lo_d     = lo_q;
    single_d = single_q;
    long_d   = long_q;
    done_d   = done_q;
    idx_d    = idx_q;
    dly_d    = (tick && (state_q == POWER || state_q == WAIT)) ? dly_q + 1'b1 : dly_q;
    case (state_q)
      POWER: if (dly_end) state_d = INIT;
      INIT:
        if (idx_q == 4'(INIT_LEN)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          state_d  = SETUP;
          data_d   = step.val;
          rs_d     = 1'b0;
          lo_d     = 1'b0;
          single_d = !step.is_byte;
          long_d   = step.long_wait;
          idx_d    = idx_q + 1'b1;
        end
      IDLE:
        if (accept) begin
          state_d  = SETUP;
          data_d   = bus.in_data;
          rs_d     = bus.in_rs;
          lo_d     = 1'b0;
          single_d = 1'b0;
          long_d   = !bus.in_rs && bus.in_data <= 8'h03;
        end
      SETUP: if (tick) state_d = EN_HI;
      EN_HI: if (tick) state_d = EN_LO;
      EN_LO:
        if (tick) begin
          state_d = (lo_q || single_q) ? WAIT : SETUP;
          lo_d    = !(lo_q || single_q) || lo_q;
        end
      WAIT: if (dly_end) state_d = done_q ? IDLE : INIT;
      default: state_d = POWER;
    endcase
    if (state_d != state_q) dly_d = '0;
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      state_q  <= POWER;
      data_q   <= '0;
      rs_q     <= 1'b0;
      lo_q     <= 1'b0;
      single_q <= 1'b0;
      long_q   <= 1'b0;
      done_q   <= 1'b0;
      idx_q    <= '0;
      dly_q    <= '0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      rs_q     <= rs_d;
      lo_q     <= lo_d;
      single_q <= single_d;
      long_q   <= long_d;
      done_q   <= done_d;
      idx_q    <= idx_d;
      dly_q    <= dly_d;
    end
  assign bus.in_ready  = state_q == IDLE && done_q;
  assign bus.init_done = done_q;
  assign bus.busy      = state_q != IDLE;
  assign bus.lcd_en    = state_q == EN_HI;
  assign bus.lcd_rs    = rs_q;
  assign bus.lcd_data  = lo_q ? data_q[3:0] : data_q[7:4];
endmodule

// File: tb/tb_lcd_sequencer.sv
// tb_lcd_sequencer: randomized writes checked against a pulse-level model of the LCD bus.
module tb_lcd_sequencer;
  localparam int DIV   = 2;
  localparam int DB    = 2;
  localparam int SHORT = 1 << DB;
  localparam int LONG  = 1 << (DB + 6);
  localparam int PWR   = 1 << (DB + 8);
  logic clk = 1'b0;
  logic rst = 1'b0;
  lcd_sequencer_if bus();
  lcd_sequencer #(.DIVIDER(DIV), .DELAY_BIT(DB)) dut (.CLK(clk), .RST(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  int n_cmp = 0, n_err = 0, cyc = 0, fall_cyc = 0, n_pulse = 0, n_acc = 0, rdy_cnt = 0;
  logic [4:0] exp_q[$];
  logic en_prev = 1'b0, p_rs = 1'b0, p_stable = 1'b0;
  logic [3:0] p_nib = '0;
  int p_w = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic nxt();
    @(negedge clk);
    #1;
  endtask
  // Pulse monitor: each completed E pulse is checked against the expected (rs,nibble) queue.
  always @(negedge clk) begin
    cyc++;
    if (bus.in_ready) rdy_cnt++;
    if (rst) en_prev = 1'b0;
    else begin
      if (bus.lcd_en && !en_prev) begin
        p_rs = bus.lcd_rs; p_nib = bus.lcd_data; p_w = 1; p_stable = 1'b1;
      end else if (bus.lcd_en) begin
        p_w++;
        if (bus.lcd_rs !== p_rs || bus.lcd_data !== p_nib) p_stable = 1'b0;
      end else if (en_prev) begin
        fall_cyc = cyc;
        n_pulse++;
        chk("pulse_width", p_w, DIV);
        chk("pulse_stable", p_stable, 1);
        if (exp_q.size() == 0) chk("pulse_unexpected", exp_q.size(), 1);
        else chk("pulse_nibble", {p_rs, p_nib}, exp_q.pop_front());
      end
      en_prev = bus.lcd_en;
    end
  end
  always @(posedge clk) if (!rst && bus.in_valid && bus.in_ready) n_acc++;
  task automatic run_init();
    int t = 0, p0 = n_pulse, a0 = n_acc;
    bit quiet = 1'b1;
    logic [3:0] seq [12] = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8, 4'h0, 4'hC, 4'h0, 4'h1, 4'h0, 4'h6};
    exp_q.delete();
    foreach (seq[i]) exp_q.push_back({1'b0, seq[i]});
    bus.in_valid = 1'b1; bus.in_data = 8'($urandom); bus.in_rs = 1'($urandom);
    while (!bus.lcd_en && t < PWR * DIV + 100) begin
      nxt(); t++;
      if (bus.in_ready || bus.init_done) quiet = 1'b0;
    end
    chk("power_wait", t >= PWR * DIV && t < PWR * DIV + 100, 1);
    t = 0;
    while (!bus.init_done && t < 4000) begin
      nxt(); t++;
      if (!bus.init_done && bus.in_ready) quiet = 1'b0;
    end
    bus.in_valid = 1'b0;
    chk("init_done", bus.init_done, 1);
    chk("init_quiet", quiet, 1);
    chk("init_pulses", n_pulse - p0, 12);
    chk("init_exp_left", exp_q.size(), 0);
    chk("init_no_accept", n_acc - a0, 0);
    chk("done_after_wait", cyc - fall_cyc >= DIV * (1 + SHORT), 1);
    chk("idle_flags", {bus.in_ready, bus.busy}, 2'b10);
  endtask
  task automatic send(input logic rs, input logic [7:0] d, input bit hold, input bit noise);
    int t = 0, a0 = n_acc;
    bit lng = !rs && d <= 8'h03;
    bus.in_valid = 1'b1; bus.in_data = d; bus.in_rs = rs;
    while (!bus.in_ready && t < 2000) begin nxt(); t++; end
    chk("accept_ready", bus.in_ready, 1);
    exp_q.push_back({rs, d[7:4]});
    exp_q.push_back({rs, d[3:0]});
    nxt();
    chk("acc_count", n_acc - a0, 1);
    chk("setup_nibble", {bus.lcd_rs, bus.lcd_data}, {rs, d[7:4]});
    chk("setup_flags", {bus.lcd_en, bus.in_ready, bus.busy}, 3'b001);
    if (!hold) begin
      bus.in_valid = 1'b0; bus.in_data = 8'($urandom); bus.in_rs = 1'($urandom);
      if (noise) begin
        for (int i = 0; i < 5; i++) begin
          bus.in_valid = 1'($urandom); bus.in_data = 8'($urandom); bus.in_rs = 1'($urandom);
          nxt();
        end
        bus.in_valid = 1'b0;
      end
    end
    t = 0;
    while (!bus.in_ready && t < 2000) begin nxt(); t++; end
    chk("ready_gap", cyc - fall_cyc, DIV * (1 + (lng ? LONG : SHORT)));
    chk("acc_during_xfer", n_acc - a0, 1);
  endtask
  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    int r0, t;
    logic r;
    logic [7:0] d;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_rs = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_outputs", {bus.lcd_en, bus.lcd_rs, bus.lcd_data, bus.in_ready, bus.init_done, bus.busy}, 9'b0_0_0000_0_0_1);
    repeat (3) nxt();
    chk("rst_hold", {bus.lcd_en, bus.lcd_rs, bus.lcd_data, bus.in_ready, bus.init_done, bus.busy}, 9'b0_0_0000_0_0_1);
    rst = 1'b0;
    run_init();
    send(1'b1, 8'h41, 1'b0, 1'b0);
    send(1'b0, 8'h01, 1'b1, 1'b0);
    bus.in_valid = 1'b0;
    r0 = rdy_cnt;
    for (int i = 0; i < 3; i++) send(1'($urandom), 8'($urandom), 1'b1, 1'b0);
    bus.in_valid = 1'b0;
    chk("b2b_ready_cycles", rdy_cnt - r0, 3);
    repeat (16) begin
      r = 1'($urandom); d = 8'($urandom);
      if ($urandom_range(0, 3) == 0) begin r = 1'b0; d = 8'($urandom_range(0, 3)); end
      repeat ($urandom_range(0, 3)) nxt();
      send(r, d, 1'b0, 1'($urandom));
    end
    bus.in_valid = 1'b1; bus.in_data = 8'($urandom); bus.in_rs = 1'b1;
    nxt();
    bus.in_valid = 1'b0;
    t = 0;
    while (!bus.lcd_en && t < 20) begin nxt(); t++; end
    chk("en_before_rst", bus.lcd_en, 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_en", bus.lcd_en, 0);
    chk("rst_async_all", {bus.lcd_en, bus.lcd_rs, bus.lcd_data, bus.in_ready, bus.init_done, bus.busy}, 9'b0_0_0000_0_0_1);
    repeat (2) nxt();
    rst = 1'b0;
    run_init();
    send(1'b1, 8'h5A, 1'b0, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/lcd_sequencer.md
LCD_SEQUENCER -- requirements
Module: lcd_sequencer

Interface
REQ-001 Parameter DIVIDER, default 12: CLK cycles per LCD timing tick.
REQ-002 Parameter DELAY_BIT, default 6: short wait = 2^DELAY_BIT ticks; long wait = 2^(DELAY_BIT+6) ticks; power-up wait = 2^(DELAY_BIT+8) ticks.
REQ-003 One clock; reset is asynchronous and active-high. Ports are listed below.
REQ-004 CLK  in  1  system clock.
REQ-005 RST  in  1  asynchronous reset, active-high.
REQ-006 in_valid  in  1  requester has a byte to write.
REQ-007 in_data  in  8  byte to write to the display.
REQ-008 in_rs  in  1  register select for the byte: 0 = command, 1 = data.
REQ-009 in_ready  out  1  the sequencer accepts a byte this cycle.
REQ-010 init_done  out  1  the power-on init sequence has completed.
REQ-011 busy  out  1  the sequencer is not in IDLE.
REQ-012 lcd_data  out  4  HD44780 DB7..DB4 nibble.
REQ-013 lcd_en  out  1  HD44780 E strobe.
REQ-014 lcd_rs  out  1  HD44780 RS.

Function
REQ-015 The state machine SHALL have these states: POWER, INIT, IDLE, SETUP, EN_HI, EN_LO, WAIT.
REQ-016 The prescaler SHALL clear on every state change and on every nibble change. SETUP, EN_HI and EN_LO SHALL each last exactly DIVIDER cycles. A wait of N ticks SHALL last N*DIVIDER cycles.
REQ-017 Nibble transfer:
- SETUP: lcd_rs and lcd_data valid, lcd_en=0.
- EN_HI: lcd_en=1.
- EN_LO: lcd_en=0, data held.
- lcd_data and lcd_rs SHALL NOT change while lcd_en=1.
REQ-018 Byte transfer SHALL be the high nibble then the low nibble (each a full SETUP/EN_HI/EN_LO), then WAIT.
REQ-019 WAIT SHALL use the long wait when rs=0 and byte<=0x03 (clear/home); otherwise the short wait.
REQ-020 POWER: outputs idle for the power-up wait, then go to INIT.
REQ-021 INIT SHALL issue this fixed sequence, all with rs=0:
- Single nibbles, each followed by its wait: 0x3 (long), 0x3 (short), 0x3 (short), 0x2 (short).
- Then bytes: 0x28, 0x0C, 0x01 (long), 0x06.
REQ-022 After the INIT sequence completes, init_done SHALL be 1 and remain 1 until reset; the state SHALL go to IDLE.
REQ-023 in_ready = 1 only in IDLE with init_done=1. A transfer is accepted when in_valid && in_ready.
REQ-024 On accept, in_data and in_rs SHALL be captured. The state SHALL be SETUP on the next cycle, with lcd_data = captured high nibble on that cycle.
REQ-025 in_valid while not ready SHALL be ignored: no capture, no side effects.
REQ-026 in_data/in_rs changing after accept SHALL NOT affect the transfer in progress.
REQ-027 Back-to-back transfers: in_ready SHALL be 1 on the first cycle after WAIT ends. With in_valid held high, there SHALL be exactly one idle cycle between transfers.
REQ-028 busy = (state != IDLE).

Reset
REQ-029 While RST=1, asynchronously and regardless of clock:
- Outputs: lcd_en=0, lcd_rs=0, lcd_data=0, in_ready=0, init_done=0, busy=1.
- Internal: state=POWER, prescaler=0, delay counter=0, init index=0.
REQ-030 Reset mid-transfer (including during EN_HI) SHALL drop lcd_en immediately. After release, the full power-up wait and INIT sequence SHALL rerun.

Structure
REQ-031 Shared package lcd_pkg SHALL hold:
- the state enum;
- the INIT sequence table (nibble/byte flag, value, long/short wait);
- constants CMD_FUNCSET=0x28, CMD_DISPON=0x0C, CMD_CLEAR=0x01, CMD_ENTRY=0x06.
REQ-032 Tick generation SHALL be a sub-module lcd_prescaler (DIVIDER parameter, sync clear input, one-cycle tick output). All other logic is in lcd_sequencer.

Verification (DIVIDER=2, DELAY_BIT=2)
REQ-033 Reset release:
- lcd_en stays 0 for 2048 cycles (1024 ticks x 2).
- in_ready=0 and init_done=0 throughout.
REQ-034 Init capture:
- Exactly 12 lcd_en pulses, each 2 cycles high.
- Sampled lcd_data sequence: 3,3,3,2,2,8,0,C,0,1,0,6.
- lcd_rs=0 on all pulses; init_done rises after the final wait.
REQ-035 Data write:
- Accept rs=1, data=0x41.
- Pulses carry 0x4 then 0x1 with lcd_rs=1.
- in_ready returns 8 cycles after WAIT starts (short wait = 4 ticks x 2).
REQ-036 Clear command:
- rs=0, data=0x01 -> WAIT lasts 512 cycles (256 ticks x 2).
- in_valid held high throughout: no second accept during WAIT.
REQ-037 Back-to-back: in_valid held high with 3 bytes -> 3 accepts, one idle cycle between transfers, bytes transferred in order.
REQ-038 Reset during EN_HI of a data write -> lcd_en=0 within the same cycle, then the full power-up/INIT sequence repeats.
